ioq_pkt_reader: RTL and testbench

- Drains a first-word-fallthrough small FIFO holding 72-bit NetFPGA words ({ctrl[7:0], data[63:0]}) and forwards them to the next stage over the out_wr/out_rdy bus.
- Tracks packet framing: module headers, payload and end-of-packet (EOP).
- Checks each packet's payload word count against the IOQ module header and reports per-packet status pulses and a packet counter.

---
 rtl/ioq_pkt_reader_if.sv | 55 +++++
 rtl/ioq_pkt_reader.sv | 152 +++++++++++++++
 tb/tb_ioq_pkt_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ioq_pkt_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : ioq_fifo_if / ioq_out_if
// Description : FWFT FIFO read port and out_wr/out_rdy word bus of the IOQ
//               packet reader.
// Revision    : 1.0 - initial release
// ============================================================================

interface ioq_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_fifo_dout;
    logic                             in_fifo_empty;
    logic                             in_fifo_rd_en;

    // master is the FIFO, slave is the reader that pops it
    modport master (
        output in_fifo_dout,
        output in_fifo_empty,
        input  in_fifo_rd_en
    );

    modport slave (
        input  in_fifo_dout,
        input  in_fifo_empty,
        output in_fifo_rd_en
    );
endinterface

interface ioq_out_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        output out_data,
        output out_ctrl,
        output out_wr,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_ctrl,
        input  out_wr,
        output out_rdy
    );
endinterface

`default_nettype wire

// File: rtl/ioq_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module      : ioq_pkt_reader
// Description : Drains a FWFT FIFO of NetFPGA words onto the out_wr bus and
//               checks each packet's payload length against its IOQ header.
// Revision    : 1.0 - initial release
// ============================================================================

module ioq_pkt_reader #(
    parameter int              DATA_WIDTH = 64,
    parameter int              CTRL_WIDTH = 8,
    parameter logic [7:0]      IOQ_CTRL   = 8'hFF,
    parameter int              CNT_WIDTH  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    ioq_fifo_if.slave                 fifo,
    ioq_out_if.master                 out,
    output logic                      pkt_done,
    output logic                      len_err,
    output logic [CNT_WIDTH-1:0]      pkt_count,
    output logic [CNT_WIDTH-1:0]      err_count
);

    localparam logic [15:0]          c_cnt_max = 16'hFFFF;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_HDR     = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_hdr_seen;
    logic                  w_hdr_seen_nxt;
    logic [15:0]           r_exp_len;
    logic [15:0]           w_exp_len_nxt;
    logic [15:0]           r_word_cnt;
    logic [15:0]           w_word_cnt_nxt;
    logic [15:0]           w_cnt_inc;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;
    logic                  r_pkt_done;
    logic                  r_len_err;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic                  w_pop;
    logic                  w_eop;
    logic                  w_eop_err;
    logic [DATA_WIDTH-1:0] w_data;
    logic [CTRL_WIDTH-1:0] w_ctrl;

    assign w_data = fifo.in_fifo_dout[DATA_WIDTH-1:0];
    assign w_ctrl = fifo.in_fifo_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

    // Downstream's out_rdy already accounts for the word sitting in the
    // output register, so popping straight off it is safe.
    assign w_pop              = !fifo.in_fifo_empty && out.out_rdy && !reset;
    assign fifo.in_fifo_rd_en = w_pop;

    assign w_cnt_inc = (r_word_cnt == c_cnt_max) ? c_cnt_max : r_word_cnt + 16'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_hdr_seen_nxt = r_hdr_seen;
        w_exp_len_nxt  = r_exp_len;
        w_word_cnt_nxt = r_word_cnt;
        w_eop          = 1'b0;
        w_eop_err      = 1'b0;

        if (w_pop) begin
            case (r_state)
                S_HDR: begin
                    if (w_ctrl != '0) begin
                        if (w_ctrl == IOQ_CTRL) begin
                            w_exp_len_nxt  = w_data[DATA_WIDTH-1 -: 16];
                            w_hdr_seen_nxt = 1'b1;
                        end
                    end else begin
                        w_word_cnt_nxt = 16'd1;
                        w_state_nxt    = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_ctrl == '0) begin
                        w_word_cnt_nxt = w_cnt_inc;
                    end else begin
                        // EOP word counts toward the payload length
                        w_eop          = 1'b1;
                        w_eop_err      = !r_hdr_seen || (w_cnt_inc != r_exp_len);
                        w_state_nxt    = S_HDR;
                        w_hdr_seen_nxt = 1'b0;
                        w_word_cnt_nxt = 16'd0;
                    end
                end
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_HDR;
            r_hdr_seen  <= 1'b0;
            r_exp_len   <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_out_wr    <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_len_err   <= 1'b0;
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hdr_seen <= w_hdr_seen_nxt;
            r_exp_len  <= w_exp_len_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_out_wr   <= w_pop;
            if (w_pop) begin
                r_out_data <= w_data;
                r_out_ctrl <= w_ctrl;
            end
            r_pkt_done <= w_eop;
            r_len_err  <= w_eop_err;
            if (w_eop) begin
                r_pkt_count <= r_pkt_count + c_cnt_one;
            end
            if (w_eop_err) begin
                r_err_count <= r_err_count + c_cnt_one;
            end
        end
    end

    assign out.out_data = r_out_data;
    assign out.out_ctrl = r_out_ctrl;
    assign out.out_wr   = r_out_wr;
    assign pkt_done     = r_pkt_done;
    assign len_err      = r_len_err;
    assign pkt_count    = r_pkt_count;
    assign err_count    = r_err_count;

    a_no_pop_empty: assert property (@(posedge clk)
        !(fifo.in_fifo_rd_en && fifo.in_fifo_empty));

endmodule

`default_nettype wire

// File: tb/tb_ioq_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioq_pkt_reader
// Description : Directed bench for ioq_pkt_reader with a packet-level
//               scoreboard of expected output words and status.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ioq_pkt_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic out_rdy = 1'b1;
    logic        pkt_done, len_err;
    logic [31:0] pkt_count, err_count;

    always #5 clk = ~clk;

    ioq_fifo_if fifo_if ();
    ioq_out_if  out_if ();

    ioq_pkt_reader dut (
        .clk       (clk),
        .reset     (reset),
        .fifo      (fifo_if),
        .out       (out_if),
        .pkt_done  (pkt_done),
        .len_err   (len_err),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    // FWFT FIFO model: storage array with push/pop pointers
    logic [71:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    assign fifo_if.in_fifo_dout  = mem[rd_ptr];
    assign fifo_if.in_fifo_empty = (rd_ptr == wr_ptr);
    assign out_if.out_rdy        = out_rdy;

    always @(posedge clk) begin
        if (fifo_if.in_fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
    end

    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] data;
        bit          done;
        bit          err;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_pkt = 0;
    int   m_err = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] ctrl, input logic [63:0] data,
                        input bit done, input bit err);
        rec_t r;
        mem[wr_ptr] = {ctrl, data};
        wr_ptr      = wr_ptr + 8'd1;
        r.ctrl = ctrl; r.data = data; r.done = done; r.err = err;
        exp_q.push_back(r);
    endtask

    // One packet: optional IOQ header, optional foreign header, npay words
    // of payload the last of which carries eop_ctrl.
    task automatic pkt(input bit has_hdr, input logic [15:0] len, input int npay,
                       input logic [7:0] eop_ctrl, input bit extra);
        bit err;
        err = !has_hdr || (npay != int'(len));
        if (has_hdr) push(8'hFF, {len, 48'h0000_1234_5678}, 1'b0, 1'b0);
        if (extra)   push(8'h22, {16'd7, 48'h0000_AAAA_BBBB}, 1'b0, 1'b0);
        for (int i = 0; i < npay; i++) begin
            bit last;
            last = (i == npay - 1);
            push(last ? eop_ctrl : 8'h00, {32'hA500_0000 + i, $urandom},
                 last, last && err);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((rd_ptr != wr_ptr || exp_q.size() != 0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, (k < 300), 1);
        @(posedge clk); #1;
    endtask

    // Compare process, sampling at the falling edge
    bit          armed = 0;
    bit          rst_prev = 0;
    bit          pop_prev = 0;
    logic [63:0] last_data = '0;
    logic [7:0]  last_ctrl = '0;

    always @(negedge clk) begin
        if (!armed) begin
            armed = 1;
        end else if (rst_prev) begin
            m_pkt = 0; m_err = 0;
            last_data = '0; last_ctrl = '0;
            check("rst_out_wr", out_if.out_wr, 0);
            check("rst_out_data", out_if.out_data, 0);
            check("rst_out_ctrl", out_if.out_ctrl, 0);
            check("rst_pkt_done", pkt_done, 0);
            check("rst_len_err", len_err, 0);
            check("rst_pkt_count", pkt_count, 0);
            check("rst_err_count", err_count, 0);
        end else begin
            check("out_wr_latency", out_if.out_wr, pop_prev);
            if (out_if.out_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    check("out_data", out_if.out_data, r.data);
                    check("out_ctrl", out_if.out_ctrl, r.ctrl);
                    check("pkt_done", pkt_done, r.done);
                    check("len_err", len_err, r.err);
                    if (r.done) m_pkt++;
                    if (r.err)  m_err++;
                end
                last_data = out_if.out_data;
                last_ctrl = out_if.out_ctrl;
            end else begin
                check("hold_data", out_if.out_data, last_data);
                check("hold_ctrl", out_if.out_ctrl, last_ctrl);
                check("idle_pkt_done", pkt_done, 0);
                check("idle_len_err", len_err, 0);
            end
            check("pkt_count", pkt_count, 32'(m_pkt));
            check("err_count", err_count, 32'(m_err));
        end
        if (armed && !rst_prev && pkt_done === 1'b1) n_done++;
        check("rd_en", fifo_if.in_fifo_rd_en,
              !fifo_if.in_fifo_empty && out_rdy && !reset);
        pop_prev = fifo_if.in_fifo_rd_en;
        rst_prev = reset;
    end

    initial begin
        bit pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("lit_reset_pkt_count", pkt_count, 0);
        check("lit_reset_out_wr", out_if.out_wr, 0);

        // basic forward: hdr len 3, words 00 00 04
        pkt(1, 16'd3, 3, 8'h04, 0);
        drain("drain_basic");
        check("lit_basic_pkt_count", pkt_count, 1);
        check("lit_basic_err_count", err_count, 0);
        check("lit_basic_done", n_done, 1);

        // length mismatch: hdr says 5, 3 words sent
        pkt(1, 16'd5, 3, 8'h04, 0);
        drain("drain_mismatch");
        check("lit_mismatch_err_count", err_count, 1);

        // missing header
        pkt(0, 16'd0, 3, 8'h80, 0);
        drain("drain_nohdr");
        check("lit_nohdr_err_count", err_count, 2);
        check("lit_nohdr_pkt_count", pkt_count, 3);

        // backpressure: 6-word packet with out_rdy 1,0,0,1
        pkt(1, 16'd5, 5, 8'h04, 0);
        for (int i = 0; i < 100 && (rd_ptr != wr_ptr || exp_q.size() != 0); i++) begin
            out_rdy = pat[i % 4];
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        drain("drain_bp");
        check("lit_bp_pkt_count", pkt_count, 4);
        check("lit_bp_done", n_done, 4);

        // back-to-back: stale IOQ hdr overwritten, one bad packet,
        // one packet carrying a foreign header word
        push(8'hFF, {16'd9, 48'h0}, 1'b0, 1'b0);
        pkt(1, 16'd2, 2, 8'h01, 0);
        pkt(1, 16'd4, 2, 8'h02, 0);
        pkt(1, 16'd3, 3, 8'h04, 1);
        drain("drain_b2b");
        check("lit_b2b_pkt_count", pkt_count, 7);
        check("lit_b2b_err_count", err_count, 3);
        check("lit_b2b_done", n_done, 7);

        // reset after two payload words
        push(8'hFF, {16'd4, 48'h0}, 1'b0, 1'b0);
        push(8'h00, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        push(8'h00, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        drain("drain_partial");
        reset = 1'b1;
        @(posedge clk); #1;
        check("lit_rst_pkt_count", pkt_count, 0);
        check("lit_rst_err_count", err_count, 0);
        check("lit_rst_out_data", out_if.out_data, 0);
        reset = 1'b0;
        pkt(0, 16'd0, 2, 8'h04, 0);
        drain("drain_after_rst");
        check("lit_after_rst_pkt_count", pkt_count, 1);
        check("lit_after_rst_err_count", err_count, 1);
        check("lit_total_done", n_done, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
